// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
// Instruction classes are also consumed by the opcode decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] CLS_ILL    = 4'b0000;
  localparam logic [3:0] CLS_R      = 4'b0001;
  localparam logic [3:0] CLS_IALU   = 4'b0010;
  localparam logic [3:0] CLS_LOAD   = 4'b0011;
  localparam logic [3:0] CLS_STORE  = 4'b0100;
  localparam logic [3:0] CLS_BRANCH = 4'b0101;
  localparam logic [3:0] CLS_JAL    = 4'b0110;
  localparam logic [3:0] CLS_JALR   = 4'b0111;
  localparam logic [3:0] CLS_LUI    = 4'b1000;
  localparam logic [3:0] CLS_AUIPC  = 4'b1001;

  localparam logic [1:0] PC_PC4  = 2'b00;
  localparam logic [1:0] PC_ALU  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic OPA_RS1 = 1'b0;
  localparam logic OPA_PC  = 1'b1;
  localparam logic OPB_RS2 = 1'b0;
  localparam logic OPB_IMM = 1'b1;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB,
// datapath enables, mux selects, memory handshakes, instret.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       code,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_en,
  output logic             pc_en,
  output logic             rf_we,
  output logic [1:0]       pc_sel,
  output logic             op_a_sel,
  output logic             op_b_sel,
  output logic             alu_funct,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_e           r_state;
  state_e           w_next;
  logic [3:0]       r_cls;
  logic             r_tkn;
  logic [CNT_W-1:0] r_instret;

  logic w_opa;
  logic w_opb;
  logic w_fn;
  logic w_alu_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_ILL;
      r_tkn     <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= code;
      if (r_state == S_EXEC) r_tkn <= br_taken;
      if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // ALU selects depend only on class; held from EXEC through WB
  always_comb begin
    w_opa = OPA_RS1;
    w_opb = OPB_RS2;
    w_fn  = 1'b0;
    case (r_cls)
      CLS_R: w_fn = 1'b1;
      CLS_IALU: begin
        w_opb = OPB_IMM;
        w_fn  = 1'b1;
      end
      CLS_LOAD, CLS_STORE, CLS_JALR: w_opb = OPB_IMM;
      CLS_BRANCH, CLS_JAL, CLS_AUIPC: begin
        w_opa = OPA_PC;
        w_opb = OPB_IMM;
      end
      default: ;
    endcase
  end

  assign w_alu_on = (r_state == S_EXEC) || (r_state == S_MEM) ||
                    (r_state == S_WB);

  always_comb begin
    w_next    = r_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    rf_we     = 1'b0;
    pc_sel    = PC_PC4;
    wb_sel    = WB_ALU;
    trap      = 1'b0;
    op_a_sel  = w_alu_on ? w_opa : 1'b0;
    op_b_sel  = w_alu_on ? w_opb : 1'b0;
    alu_funct = w_alu_on ? w_fn : 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_en  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = (code == CLS_ILL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        if (r_cls == CLS_LOAD || r_cls == CLS_STORE) w_next = S_MEM;
        else w_next = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_cls == CLS_STORE);
        if (dmem_ack) w_next = S_WB;
      end
      S_WB: begin
        pc_en = 1'b1;
        rf_we = (r_cls != CLS_STORE) && (r_cls != CLS_BRANCH);
        if ((r_cls == CLS_BRANCH && r_tkn) || r_cls == CLS_JAL)
          pc_sel = PC_ALU;
        else if (r_cls == CLS_JALR)
          pc_sel = PC_JALR;
        case (r_cls)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          CLS_LUI:           wb_sel = WB_IMM;
          default:           wb_sel = WB_ALU;
        endcase
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        trap      = 1'b1;
        op_a_sel  = 1'b0;
        op_b_sel  = 1'b0;
        alu_funct = 1'b0;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl, built with a 4-bit
// instret so the wrap is reachable in a short run.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] code;
  logic       br_taken;
  logic       imem_ack;
  logic       dmem_ack;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_en;
  logic       pc_en;
  logic       rf_we;
  logic [1:0] pc_sel;
  logic       op_a_sel;
  logic       op_b_sel;
  logic       alu_funct;
  logic [1:0] wb_sel;
  logic       trap;
  logic [3:0] instret;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_ret = 4'd0;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .code(code),
    .br_taken(br_taken), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_en(ir_en),
    .pc_en(pc_en), .rf_we(rf_we), .pc_sel(pc_sel),
    .op_a_sel(op_a_sel), .op_b_sel(op_b_sel),
    .alu_funct(alu_funct), .wb_sel(wb_sel), .trap(trap),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH with a zero-wait imem.
  task automatic instr(input logic [3:0] c, input logic br,
                       input int mw, input logic ea,
                       input logic eb, input logic ef,
                       input logic [1:0] epc, input logic erf,
                       input logic [1:0] ewb, input logic ewe);
    imem_ack = 1'b1;
    #1;
    chk("fetch_req", imem_req, 1);
    chk("fetch_ir_en", ir_en, 1);
    tick();
    imem_ack = 1'b0;
    code = c;
    #1;
    chk("decode_req", imem_req, 0);
    tick();
    code = 4'hF;
    br_taken = br;
    #1;
    chk("exec_op_a", op_a_sel, ea);
    chk("exec_op_b", op_b_sel, eb);
    chk("exec_funct", alu_funct, ef);
    tick();
    br_taken = 1'b0;
    if (c == CLS_LOAD || c == CLS_STORE) begin
      for (int i = 0; i <= mw; i++) begin
        dmem_ack = (i == mw);
        imem_ack = 1'b1;
        #1;
        chk("mem_dreq", dmem_req, 1);
        chk("mem_ireq", imem_req, 0);
        chk("mem_we", dmem_we, ewe);
        chk("mem_op_b", op_b_sel, eb);
        tick();
      end
      dmem_ack = 1'b0;
      imem_ack = 1'b0;
    end
    #1;
    chk("wb_pc_en", pc_en, 1);
    chk("wb_pc_sel", pc_sel, epc);
    chk("wb_rf_we", rf_we, erf);
    chk("wb_sel", wb_sel, ewb);
    chk("wb_op_a", op_a_sel, ea);
    tick();
    exp_ret = exp_ret + 4'd1;
    chk("instret", instret, exp_ret);
    chk("refetch_req", imem_req, 1);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    code = 4'h0;
    br_taken = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    tick();
    tick();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_trap", trap, 0);
    chk("rst_instret", instret, 0);
    rst = 1'b0;
    tick();
    chk("idle_hold", imem_req, 0);
    run = 1'b1;
    tick();
    //    code        br mw a  b  f  pc     rf wb     we
    instr(CLS_R,      0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0);
    instr(CLS_LOAD,   0, 3, 0, 1, 0, 2'b00, 1, 2'b01, 0);
    instr(CLS_BRANCH, 1, 0, 1, 1, 0, 2'b01, 0, 2'b00, 0);
    instr(CLS_BRANCH, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 0);
    instr(CLS_JALR,   0, 0, 0, 1, 0, 2'b10, 1, 2'b10, 0);
    instr(CLS_STORE,  0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1);
    instr(CLS_JAL,    0, 0, 1, 1, 0, 2'b01, 1, 2'b10, 0);
    instr(CLS_LUI,    0, 0, 0, 0, 0, 2'b00, 1, 2'b11, 0);
    instr(CLS_AUIPC,  0, 0, 1, 1, 0, 2'b00, 1, 2'b00, 0);
    instr(CLS_IALU,   0, 0, 0, 1, 1, 2'b00, 1, 2'b00, 0);
    for (int k = 0; k < 6; k++)
      instr(CLS_R,    0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0);
    chk("wrap_16", instret, 0);
    instr(CLS_R,      0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 0);
    chk("after_wrap", instret, 1);

    chk("pre_rst_req", imem_req, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_ret", instret, 0);
    tick();
    rst = 1'b0;
    run = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("late_ack_ir", ir_en, 0);
    tick();
    chk("late_ack_idle", imem_req, 0);
    imem_ack = 1'b0;

    run = 1'b1;
    tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    code = CLS_ILL;
    tick();
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      dmem_ack = i[1];
      #1;
      chk("trap_flag", trap, 1);
      chk("trap_ireq", imem_req, 0);
      chk("trap_pc_en", pc_en, 0);
      chk("trap_ret", instret, 0);
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("trap_cleared", trap, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
